// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, port ids
// and the latency counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int unsigned LAT_W = 4;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, and a tie goes to
// the port that did not win last time.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt_onehot
);

    always_comb begin
        gnt_onehot = '0;
        if (req[PORT_CPU] && (!req[PORT_DBG] || last == PORT_DBG))
            gnt_onehot[PORT_CPU] = 1'b1;
        else if (req[PORT_DBG])
            gnt_onehot[PORT_DBG] = 1'b1;
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one data-memory port between the CPU load/store path (port 0) and the
// loader/debug master (port 1); one transaction in flight, MEM_LAT read latency.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r0_busy,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state;
    logic              last;
    logic              owner;
    logic              cap_we;
    logic [LAT_W-1:0]  lat_cnt;
    logic [1:0]        pick;
    logic [1:0]        gnt;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    rr_arb2 u_arb (
        .req        ({r1_req, r0_req}),
        .last       (last),
        .gnt_onehot (pick)
    );

    assign gnt    = (state == ST_IDLE) ? pick : 2'b00;
    assign r0_gnt = gnt[PORT_CPU];
    assign r1_gnt = gnt[PORT_DBG];

    assign r0_busy = (r0_req || (state != ST_IDLE && owner == PORT_CPU)) && !r0_done;

    always_comb begin
        win_we    = r0_we;
        win_addr  = r0_addr;
        win_wdata = r0_wdata;
        if (gnt[PORT_DBG]) begin
            win_we    = r1_we;
            win_addr  = r1_addr;
            win_wdata = r1_wdata;
        end
    end

    // mem_addr/mem_wdata double as the captured request; they are loaded on the
    // grant edge and cleared again after the single ISSUE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            last      <= PORT_DBG;
            owner     <= PORT_CPU;
            cap_we    <= 1'b0;
            lat_cnt   <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            r0_done   <= 1'b0;
            r1_done   <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            r0_done   <= 1'b0;
            r1_done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        owner     <= gnt[PORT_DBG];
                        last      <= gnt[PORT_DBG];
                        cap_we    <= win_we;
                        mem_re    <= !win_we;
                        mem_we    <= win_we;
                        mem_addr  <= win_addr;
                        mem_wdata <= win_wdata;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cap_we) begin
                        r0_done <= (owner == PORT_CPU);
                        r1_done <= (owner == PORT_DBG);
                        state   <= ST_DONE;
                    end else begin
                        lat_cnt <= LAT_W'(1);
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == LAT_W'(MEM_LAT)) begin
                        if (owner == PORT_DBG)
                            r1_rdata <= mem_rdata;
                        else
                            r0_rdata <= mem_rdata;
                        r0_done <= (owner == PORT_CPU);
                        r1_done <= (owner == PORT_DBG);
                        state   <= ST_DONE;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
